// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: show-ahead valid/ready output,
// sticky overflow flag and saturating receive-error counter.
module uart_rx_fifo #(
    parameter int Depth  = 16,
    parameter int ErrMax = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   rxData,
    input  logic                         rxDone,
    input  logic                         rxErr,
    input  logic                         clear,
    output logic [7:0]                   outData,
    output logic                         outValid,
    input  logic                         outReady,
    output logic [$clog2(Depth+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow,
    output logic [7:0]                   errCount
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [7:0]      mem [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            pop;
    logic            push;
    logic            is_full;
    logic            is_empty;

    assign is_full  = (count_q == CntW'(Depth));
    assign is_empty = (count_q == '0);
    assign pop      = !is_empty && outReady;
    assign push     = rxDone && (!is_full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            err_cnt_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (rxDone && is_full && !pop) overflow_d = 1'b1;
            if (rxErr && (err_cnt_q != 8'(ErrMax))) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Storage has no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (!reset && !clear && push) mem[wr_ptr_q] <= rxData;
    end

    assign outData  = is_empty ? 8'h00 : mem[rd_ptr_q];
    assign outValid = !is_empty;
    assign count    = count_q;
    assign full     = is_full;
    assign overflow = overflow_q;
    assign errCount = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (Depth=16, ErrMax=255).
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rxData;
    logic       rxDone;
    logic       rxErr;
    logic       clear;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic [7:0] errCount;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(.Depth(16), .ErrMax(255)) dut (
        .clk      (clk),
        .reset    (reset),
        .rxData   (rxData),
        .rxDone   (rxDone),
        .rxErr    (rxErr),
        .clear    (clear),
        .outData  (outData),
        .outValid (outValid),
        .outReady (outReady),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .errCount (errCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rxData = b;
        rxDone = 1'b1;
        tick();
        rxDone = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(outValid), 32'd1);
        chk({tag, "_data"}, 32'(outData), 32'(exp));
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rxData = '0; rxDone = 0; rxErr = 0; clear = 0; outReady = 0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", 32'(outValid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_data", 32'(outData), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_err", 32'(errCount), 0);

        // single byte, latency 1
        push_byte(8'hA5);
        chk("t1_valid", 32'(outValid), 1);
        chk("t1_data", 32'(outData), 32'hA5);
        chk("t1_count", 32'(count), 1);
        outReady = 1'b1; tick(); outReady = 1'b0;
        chk("t1_empty_valid", 32'(outValid), 0);
        chk("t1_empty_count", 32'(count), 0);

        // fill and drain, pointers wrap
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), 16);
        for (int i = 0; i < 16; i++) pop_expect("t2_drain", 8'(i));
        chk("t2_count_end", 32'(count), 0);
        chk("t2_full_end", 32'(full), 0);

        // overflow drop, then push+pop while full
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        push_byte(8'h77);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_count", 32'(count), 16);
        chk("t3_head", 32'(outData), 0);
        rxData = 8'h10; rxDone = 1'b1; outReady = 1'b1;
        tick();
        rxDone = 1'b0; outReady = 1'b0;
        chk("t3_count_pp", 32'(count), 16);
        chk("t3_ovf_sticky", 32'(overflow), 1);
        for (int i = 1; i <= 16; i++) pop_expect("t3_drain", 8'(i));
        chk("t3_count_end", 32'(count), 0);

        // simultaneous push/pop at count 3
        push_byte(8'h0A); push_byte(8'h0B); push_byte(8'h0C);
        chk("t4_count3", 32'(count), 3);
        rxData = 8'h0D; rxDone = 1'b1; outReady = 1'b1;
        tick();
        rxDone = 1'b0; outReady = 1'b0;
        chk("t4_count_pp", 32'(count), 3);
        pop_expect("t4_b", 8'h0B);
        pop_expect("t4_c", 8'h0C);
        pop_expect("t4_d", 8'h0D);
        chk("t4_empty", 32'(outValid), 0);
        // outReady with empty FIFO must not underflow
        outReady = 1'b1; tick(); outReady = 1'b0;
        chk("t4_no_underflow", 32'(count), 0);

        // error saturation then clear with coincident rxDone
        push_byte(8'h33);
        rxErr = 1'b1;
        for (int i = 0; i < 254; i++) tick();
        rxErr = 1'b0;
        chk("t5_err254", 32'(errCount), 254);
        rxErr = 1'b1;
        for (int i = 0; i < 46; i++) tick();
        rxErr = 1'b0;
        chk("t5_err_sat", 32'(errCount), 255);
        clear = 1'b1; rxData = 8'h44; rxDone = 1'b1; rxErr = 1'b1;
        tick();
        clear = 1'b0; rxDone = 1'b0; rxErr = 1'b0;
        chk("t5_clr_err", 32'(errCount), 0);
        chk("t5_clr_count", 32'(count), 0);
        chk("t5_clr_ovf", 32'(overflow), 0);
        chk("t5_clr_valid", 32'(outValid), 0);
        tick();
        chk("t5_not_stored", 32'(outValid), 0);

        // coincident rxErr and rxDone, then reset mid-stream
        rxErr = 1'b1;
        push_byte(8'h51);
        rxErr = 1'b0;
        chk("t6_err_coinc", 32'(errCount), 1);
        for (int i = 2; i <= 5; i++) push_byte(8'h50 + 8'(i));
        chk("t6_count5", 32'(count), 5);
        chk("t6_head", 32'(outData), 32'h51);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("t6_valid", 32'(outValid), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_data", 32'(outData), 0);
        chk("t6_err", 32'(errCount), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
